// File: rtl/lf_spi_cfg_pkg.sv
// lf_cfg_pkg: opcodes, reset constants and FSM states for the LF SPI config receiver
package lf_cfg_pkg;
  localparam logic [3:0] CMD_SET_CONF       = 4'h1;
  localparam logic [3:0] CMD_SET_DIVISOR    = 4'h2;
  localparam logic [3:0] CMD_SET_USER_BYTE1 = 4'h3;
  localparam logic [7:0] CONF_RESET     = 8'hE0;
  localparam logic [7:0] DIVISOR_RESET  = 8'd95;
  localparam logic [7:0] THRESH_DEFAULT = 8'd127;
  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;
endpackage

// File: rtl/lf_spi_cfg_if.sv
// lf_spi_cfg_if: ARM SPI pins (spck, mosi, ncs from master; miso back to master)
interface lf_spi_cfg_if;
  logic spck;
  logic mosi;
  logic ncs;
  logic miso;
  modport master (output spck, mosi, ncs, input miso);
  modport slave (input spck, mosi, ncs, output miso);
endinterface

// File: rtl/lf_sync.sv
// lf_sync: STAGES-deep single-bit synchronizer, async active-low reset to RST_VAL
// Ports: clk, rst_n, d (async input), q (synchronized output)
module lf_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {STAGES{RST_VAL}};
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/lf_spi_cfg.sv
// lf_spi_cfg: pck0-synchronous SPI config receiver for conf_word/divisor/user_byte1
// Ports: pck0, nrst (async active-low), spi (slave modport: spck/mosi/ncs in, miso out),
//   conf_word, major_mode, divisor, user_byte1 (config registers),
//   cfg_strobe (register update pulse), frame_err (discarded frame pulse).
// Macro LF_SPI_CFG_READBACK_EN builds the {conf_word, divisor} readback on miso.
module lf_spi_cfg
  import lf_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         pck0,
  input  logic         nrst,
  lf_spi_cfg_if.slave  spi,
  output logic [7:0]   conf_word,
  output logic [2:0]   major_mode,
  output logic [7:0]   divisor,
  output logic [7:0]   user_byte1,
  output logic         cfg_strobe,
  output logic         frame_err
);
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);
  logic spck_s, mosi_s, ncs_s, spck_h, ncs_h;
  logic [1:0] settle;
  logic armed;
  logic [15:0] rx;
  logic [4:0] bitcnt;
  state_t state, state_n;
  lf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_spck (.clk(pck0), .rst_n(nrst), .d(spi.spck), .q(spck_s));
  lf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(pck0), .rst_n(nrst), .d(spi.mosi), .q(mosi_s));
  lf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs  (.clk(pck0), .rst_n(nrst), .d(spi.ncs),  .q(ncs_s));
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) begin
      spck_h <= 1'b0;
      ncs_h  <= 1'b1;
    end else begin
      spck_h <= spck_s;
      ncs_h  <= ncs_s;
    end
  wire spck_rise = spck_s & ~spck_h;
  wire ncs_fall  = ncs_h & ~ncs_s;
  wire ncs_rise  = ncs_s & ~ncs_h;
  // The synchronizer holds its reset value for SYNC_STAGES cycles after release;
  // only a real high sample of ncs arms frame reception, so a release with ncs
  // already low waits for a full high-then-low cycle.
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != SETTLE) settle <= settle + 2'd1;
      armed <= armed | ((settle == SETTLE) & ncs_s);
    end
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = (ncs_fall & armed) ? RECV : IDLE;
      RECV:    state_n = ncs_rise ? COMMIT : RECV;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // ~ncs_s also drops an spck rise seen in the same sample as the ncs rise
  wire start = (state == IDLE) & ncs_fall & armed;
  wire take  = (state == RECV) & spck_rise & ~ncs_s;
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) begin
      rx     <= 16'd0;
      bitcnt <= 5'd0;
    end else if (start) begin
      bitcnt <= 5'd0;
    end else if (take) begin
      rx     <= {rx[14:0], mosi_s};
      bitcnt <= (bitcnt == 5'd17) ? bitcnt : bitcnt + 5'd1;
    end
  wire       commit = (state == COMMIT);
  wire       len_ok = (bitcnt == 5'd16);
  wire [3:0] op     = rx[15:12];
  wire       wr_cf  = commit & len_ok & (op == CMD_SET_CONF);
  wire       wr_dv  = commit & len_ok & (op == CMD_SET_DIVISOR);
  wire       wr_ub  = commit & len_ok & (op == CMD_SET_USER_BYTE1);
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) begin
      conf_word  <= CONF_RESET;
      divisor    <= DIVISOR_RESET;
      user_byte1 <= THRESH_DEFAULT;
      cfg_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_cf) conf_word <= rx[7:0];
      if (wr_dv) divisor <= rx[7:0];
      if (wr_ub | (wr_cf & (rx[7:0] == 8'h01))) user_byte1 <= wr_ub ? rx[7:0] : THRESH_DEFAULT;
      cfg_strobe <= wr_cf | wr_dv | wr_ub;
      frame_err  <= commit & ~len_ok;
    end
  assign major_mode = conf_word[7:5];
`ifdef LF_SPI_CFG_READBACK_EN
  logic [15:0] tx;
  wire spck_fall = spck_h & ~spck_s;
  always_ff @(posedge pck0 or negedge nrst)
    if (!nrst) tx <= 16'd0;
    else if (ncs_fall) tx <= {conf_word, divisor};
    else if (spck_fall & ~ncs_s) tx <= {tx[14:0], 1'b0};
  assign spi.miso = tx[15] & ~ncs_s;
`else
  assign spi.miso = 1'b0;
`endif
endmodule

// File: tb/tb_lf_spi_cfg.sv
// tb_lf_spi_cfg: randomized SPI frames checked against a register-level model of lf_spi_cfg
module tb_lf_spi_cfg;
  logic pck0 = 1'b0;
  logic nrst = 1'b0;
  logic [7:0] conf_word, divisor, user_byte1;
  logic [2:0] major_mode;
  logic cfg_strobe, frame_err;
  int checks = 0, errors = 0;
  int n_strobe = 0, n_err = 0;
  time t_rise = 0, t_strobe = 0;
  logic [7:0] m_conf = 8'hE0, m_div = 8'd95, m_ub = 8'd127;
  int half = 4;
  always #5 pck0 = ~pck0;
  lf_spi_cfg_if spi();
  lf_spi_cfg dut (
    .pck0(pck0), .nrst(nrst), .spi(spi),
    .conf_word(conf_word), .major_mode(major_mode), .divisor(divisor),
    .user_byte1(user_byte1), .cfg_strobe(cfg_strobe), .frame_err(frame_err)
  );
  always @(negedge pck0) begin
    if (cfg_strobe) begin
      n_strobe++;
      t_strobe = $time;
    end
    if (frame_err) n_err++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge pck0);
  endtask
  task automatic shift_bits(input logic [63:0] d, input int n, output logic [15:0] rb);
    rb = 16'd0;
    for (int i = n - 1; i >= 0; i--) begin
      spi.mosi = d[i];
      cyc(half);
      rb = {rb[14:0], spi.miso};
      spi.spck = 1'b1;
      cyc(half);
      spi.spck = 1'b0;
    end
  endtask
  task automatic check_regs(input string tag);
    check({tag, "_conf"}, conf_word, m_conf);
    check({tag, "_div"}, divisor, m_div);
    check({tag, "_ub1"}, user_byte1, m_ub);
    check({tag, "_mode"}, major_mode, m_conf[7:5]);
  endtask
  // Register-level model: a frame is only acted on when exactly 16 bits arrived.
  task automatic model(input logic [15:0] f, input int n, output int es, output int ee);
    es = 0;
    ee = 0;
    if (n != 16) ee = 1;
    else if (f[15:12] == 4'h1) begin
      m_conf = f[7:0];
      if (f[7:0] == 8'h01) m_ub = 8'd127;
      es = 1;
    end else if (f[15:12] == 4'h2) begin
      m_div = f[7:0];
      es = 1;
    end else if (f[15:12] == 4'h3) begin
      m_ub = f[7:0];
      es = 1;
    end
  endtask
  task automatic frame(input logic [63:0] d, input int n);
    logic [15:0] rb, exp_rb;
    int s0, e0, es, ee;
    exp_rb = {m_conf, m_div};
    s0 = n_strobe;
    e0 = n_err;
    half = $urandom_range(4, 6);
    spi.ncs = 1'b0;
    cyc($urandom_range(6, 10));
    shift_bits(d, n, rb);
    cyc(half);
    spi.ncs = 1'b1;
    t_rise = $time;
    cyc(12);
    model(d[15:0], n, es, ee);
    check("strobes", n_strobe - s0, es);
    check("frame_errs", n_err - e0, ee);
    if (es != 0) check("strobe_latency", 32'((t_strobe - t_rise) / 10), 4);
    check_regs("frame");
    check("miso_idle", spi.miso, 1'b0);
`ifdef LF_SPI_CFG_READBACK_EN
    if (n == 16) check("readback", rb, exp_rb);
`else
    if (n == 16) check("miso_tied", rb, 16'd0);
`endif
  endtask
  initial begin
    logic [15:0] rb;
    logic [63:0] d;
    int n, s0, e0;
    spi.spck = 1'b0;
    spi.mosi = 1'b0;
    spi.ncs  = 1'b1;
    cyc(3);
    check_regs("reset");
    check("reset_strobe", cfg_strobe, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_miso", spi.miso, 1'b0);
    nrst = 1'b1;
    cyc(6);
    frame(64'h2059, 16);
    frame(64'h3040, 16);
    frame(64'h1001, 16);
    frame(64'h7FFF, 15);
    frame(64'h1_2033, 17);
    frame(64'h50AA, 16);
    frame(64'h0000_1234_5678_2077, 48);
    s0 = n_strobe;
    e0 = n_err;
    half = 4;
    spi.ncs = 1'b0;
    cyc(8);
    shift_bits(64'h10, 8, rb);
    nrst = 1'b0;
    #1;
    m_conf = 8'hE0;
    m_div  = 8'd95;
    m_ub   = 8'd127;
    check_regs("async_reset");
    cyc(3);
    nrst = 1'b1;
    shift_bits(64'h20, 8, rb);
    cyc(4);
    spi.ncs = 1'b1;
    cyc(12);
    check("rst_frame_strobes", n_strobe - s0, 0);
    check("rst_frame_errs", n_err - e0, 0);
    check_regs("rst_frame");
    frame(64'h1020, 16);
    frame(64'h2059, 16);
    frame(64'h0000, 16);
    for (int i = 0; i < 40; i++) begin
      d = {$urandom, $urandom};
      d[15:12] = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) d[7:0] = 8'h01;
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 18) : 16;
      frame(d, n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
